// File: rtl/cd_manchester_tx_if.sv
// Upstream byte handshake between the command-word controller and the Manchester coder.
// The controller drives the master side and the coder owns cd_busy.
interface cd_manchester_tx_if;
   logic [7:0] d;
   logic       d_rdy;
   logic       msg_end;
   logic       cd_busy;

   modport master (
      output d,
      output d_rdy,
      output msg_end,
      input  cd_busy
   );

   modport slave (
      input  d,
      input  d_rdy,
      input  msg_end,
      output cd_busy
   );
endinterface

// File: rtl/cd_manchester_tx.sv
// Manchester line coder: serialises bytes MSB-first as half-bits and pads messages with an idle gap.
// Define CD_PARITY_EN to append an odd-parity bit after each byte.
module cd_manchester_tx #(
   parameter int unsigned HALF_BIT_CLKS = 4,
   parameter int unsigned GAP_BITS      = 3
) (
   input  logic                clk,
   input  logic                rst,
   cd_manchester_tx_if.slave   bus,
   output logic                tx_line,
   output logic                tx_oe
);

   localparam int unsigned HbW     = (HALF_BIT_CLKS > 1) ? $clog2(HALF_BIT_CLKS) : 1;
   localparam int unsigned GapClks = GAP_BITS * 2 * HALF_BIT_CLKS;
   localparam int unsigned GapW    = (GapClks > 1) ? $clog2(GapClks) : 1;
   localparam logic [HbW-1:0]  HbLast  = HbW'(HALF_BIT_CLKS - 1);
   localparam logic [GapW-1:0] GapLast = GapW'(GapClks - 1);

`ifdef CD_PARITY_EN
   typedef enum logic [1:0] {StIdle = 2'd0, StShift = 2'd1, StGap = 2'd2, StPar = 2'd3} state_e;
`else
   typedef enum logic [1:0] {StIdle = 2'd0, StShift = 2'd1, StGap = 2'd2} state_e;
`endif

   state_e          r_state, w_state_d;
   logic [7:0]      r_shift, w_shift_d;
   logic [3:0]      r_bit_cnt, w_bit_cnt_d;
   logic [HbW-1:0]  r_hb_cnt, w_hb_cnt_d;
   logic [GapW-1:0] r_gap_cnt, w_gap_cnt_d;
   logic            r_pend, w_pend_d;
   logic            w_hb_last, w_exit, w_gap_entry;
`ifdef CD_PARITY_EN
   logic            r_par, w_par_d;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= StIdle;
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_hb_cnt  <= '0;
         r_gap_cnt <= '0;
         r_pend    <= 1'b0;
`ifdef CD_PARITY_EN
         r_par     <= 1'b0;
`endif
      end else begin
         r_state   <= w_state_d;
         r_shift   <= w_shift_d;
         r_bit_cnt <= w_bit_cnt_d;
         r_hb_cnt  <= w_hb_cnt_d;
         r_gap_cnt <= w_gap_cnt_d;
         r_pend    <= w_pend_d;
`ifdef CD_PARITY_EN
         r_par     <= w_par_d;
`endif
      end
   end

   // Bit counter counts half-bits; its LSB is the Manchester phase within a bit.
   always_comb begin
      w_state_d   = r_state;
      w_shift_d   = r_shift;
      w_bit_cnt_d = r_bit_cnt;
      w_hb_cnt_d  = r_hb_cnt;
      w_gap_cnt_d = r_gap_cnt;
      w_exit      = 1'b0;
      w_gap_entry = 1'b0;
      w_hb_last   = (r_hb_cnt == HbLast);
`ifdef CD_PARITY_EN
      w_par_d     = r_par;
`endif
      unique case (r_state)
         StIdle: begin
            if (r_pend) begin
               w_gap_entry = 1'b1;
            end else if (bus.d_rdy) begin
               w_state_d   = StShift;
               w_shift_d   = bus.d;
               w_bit_cnt_d = '0;
               w_hb_cnt_d  = '0;
`ifdef CD_PARITY_EN
               w_par_d     = ~(^bus.d);
`endif
            end
         end
         StShift: begin
            if (!w_hb_last) begin
               w_hb_cnt_d = r_hb_cnt + HbW'(1);
            end else begin
               w_hb_cnt_d = '0;
               if (r_bit_cnt == 4'd15) begin
`ifdef CD_PARITY_EN
                  w_state_d   = StPar;
                  w_shift_d   = {r_par, 7'd0};
                  w_bit_cnt_d = '0;
`else
                  w_exit = 1'b1;
`endif
               end else begin
                  w_bit_cnt_d = r_bit_cnt + 4'd1;
                  if (r_bit_cnt[0]) w_shift_d = {r_shift[6:0], 1'b0};
               end
            end
         end
`ifdef CD_PARITY_EN
         StPar: begin
            if (!w_hb_last) begin
               w_hb_cnt_d = r_hb_cnt + HbW'(1);
            end else begin
               w_hb_cnt_d = '0;
               if (r_bit_cnt == 4'd1) w_exit = 1'b1;
               else                   w_bit_cnt_d = r_bit_cnt + 4'd1;
            end
         end
`endif
         StGap: begin
            if (r_gap_cnt == GapLast) w_state_d = StIdle;
            else                      w_gap_cnt_d = r_gap_cnt + GapW'(1);
         end
         default: w_state_d = StIdle;
      endcase

      if (w_exit) begin
         if (r_pend) w_gap_entry = 1'b1;
         else        w_state_d   = StIdle;
      end
      if (w_gap_entry) begin
         w_state_d   = StGap;
         w_gap_cnt_d = '0;
      end
   end

   // Set-dominant: a strobe coinciding with gap entry keeps the request alive.
   assign w_pend_d = bus.msg_end | (r_pend & ~w_gap_entry);

   assign bus.cd_busy = (r_state != StIdle);
   assign tx_oe       = (r_state != StIdle);
`ifdef CD_PARITY_EN
   assign tx_line = ((r_state == StShift) || (r_state == StPar)) ? (r_shift[7] ^ r_bit_cnt[0])
                                                                 : 1'b0;
`else
   assign tx_line = (r_state == StShift) ? (r_shift[7] ^ r_bit_cnt[0]) : 1'b0;
`endif

endmodule

// File: tb/tb_cd_manchester_tx.sv
// Randomised bench for cd_manchester_tx against a per-cycle waveform model of the line code.
module tb_cd_manchester_tx;
   localparam int HBC = 2;
   localparam int GB  = 3;
`ifdef CD_PARITY_EN
   localparam int NumHalf = 18;
`else
   localparam int NumHalf = 16;
`endif
   localparam int ByteClks = NumHalf * HBC;
   localparam int GapClks  = GB * 2 * HBC;

   logic clk = 1'b0;
   logic rst;
   logic tx_line, tx_oe;
   int   n_tests = 0;
   int   n_fail  = 0;

   cd_manchester_tx_if bus ();

   cd_manchester_tx #(.HALF_BIT_CLKS(HBC), .GAP_BITS(GB)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .tx_line (tx_line),
      .tx_oe   (tx_oe)
   );

   always #5 clk = ~clk;

   // Expected line level cyc cycles after the byte is accepted.
   function automatic logic exp_line(input logic [7:0] b, input int cyc);
      int   hb;
      int   bi;
      logic v;
      hb = cyc / HBC;
      bi = hb / 2;
      if (bi < 8) v = b[7 - bi];
      else        v = ~(^b);
      return (hb % 2 == 0) ? v : ~v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.d_rdy = 1'b0;
      bus.msg_end = 1'b0;
      bus.d = 8'h00;
      for (int i = 0; i < 6; i++) begin
         if (i == 3) rst = 1'b0;
         tick();
         n_tests++;
         if ({bus.cd_busy, tx_oe, tx_line} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_idle cyc=%0d busy/oe/line got=%b exp=000", i,
                     {bus.cd_busy, tx_oe, tx_line});
         end
      end
   endtask

   task automatic test_single();
      logic [7:0] b = 8'hA5;
      bus.d = b;
      bus.d_rdy = 1'b1;
      tick();
      bus.d_rdy = 1'b0;
      for (int i = 0; i < ByteClks; i++) begin
         n_tests++;
         if ({bus.cd_busy, tx_oe, tx_line} !== {2'b11, exp_line(b, i)}) begin
            n_fail++;
            $display("FAIL single_a5 cyc=%0d busy/oe/line got=%b exp=%b", i,
                     {bus.cd_busy, tx_oe, tx_line}, {2'b11, exp_line(b, i)});
         end
         tick();
      end
      n_tests++;
      if ({bus.cd_busy, tx_oe, tx_line} !== 3'b000) begin
         n_fail++;
         $display("FAIL single_end busy/oe/line got=%b exp=000", {bus.cd_busy, tx_oe, tx_line});
      end
   endtask

   task automatic test_random();
      logic [7:0] b;
      int         gap;
      for (int k = 0; k < 6; k++) begin
         b = 8'($urandom);
         bus.d = b;
         bus.d_rdy = 1'b1;
         tick();
         for (int i = 0; i < ByteClks; i++) begin
            bus.d = 8'($urandom);
            n_tests++;
            if ({bus.cd_busy, tx_line} !== {1'b1, exp_line(b, i)}) begin
               n_fail++;
               $display("FAIL random_byte b=%h cyc=%0d busy/line got=%b exp=%b", b, i,
                        {bus.cd_busy, tx_line}, {1'b1, exp_line(b, i)});
            end
            if (i == ByteClks - 1) bus.d_rdy = 1'b0;
            tick();
         end
         n_tests++;
         if (bus.cd_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL random_gap b=%h busy got=%b exp=0", b, bus.cd_busy);
         end
         gap = int'($urandom_range(0, 3));
         for (int g = 0; g < gap; g++) tick();
      end
   endtask

   task automatic test_back_to_back();
      logic prev;
      int   rises = 0;
      prev = bus.cd_busy;
      bus.d = 8'h00;
      bus.d_rdy = 1'b1;
      tick();
      bus.d = 8'hFF;
      for (int i = 0; i < ByteClks; i++) begin
         if (bus.cd_busy && !prev) rises++;
         prev = bus.cd_busy;
         n_tests++;
         if (tx_line !== exp_line(8'h00, i)) begin
            n_fail++;
            $display("FAIL b2b_first cyc=%0d line got=%b exp=%b", i, tx_line, exp_line(8'h00, i));
         end
         tick();
      end
      prev = bus.cd_busy;
      n_tests++;
      if (bus.cd_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_low_cycle busy got=%b exp=0", bus.cd_busy);
      end
      tick();
      bus.d_rdy = 1'b0;
      for (int i = 0; i < ByteClks; i++) begin
         if (bus.cd_busy && !prev) rises++;
         prev = bus.cd_busy;
         n_tests++;
         if ({bus.cd_busy, tx_line} !== {1'b1, exp_line(8'hFF, i)}) begin
            n_fail++;
            $display("FAIL b2b_second cyc=%0d busy/line got=%b exp=%b", i,
                     {bus.cd_busy, tx_line}, {1'b1, exp_line(8'hFF, i)});
         end
         tick();
      end
      n_tests++;
      if (rises !== 2 || bus.cd_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_rises rises got=%0d exp=2 final_busy got=%b exp=0", rises, bus.cd_busy);
      end
   endtask

   // same_cycle=1 raises msg_end together with d_rdy; otherwise it is pulsed mid-byte.
   task automatic test_msg_end(input bit same_cycle);
      logic [7:0] b;
      b = 8'($urandom);
      bus.d = b;
      bus.d_rdy = 1'b1;
      bus.msg_end = same_cycle;
      tick();
      bus.d_rdy = 1'b0;
      bus.msg_end = 1'b0;
      for (int i = 0; i < ByteClks; i++) begin
         if (!same_cycle) bus.msg_end = (i == ByteClks / 2);
         n_tests++;
         if ({bus.cd_busy, tx_line} !== {1'b1, exp_line(b, i)}) begin
            n_fail++;
            $display("FAIL msg_byte b=%h cyc=%0d busy/line got=%b exp=%b", b, i,
                     {bus.cd_busy, tx_line}, {1'b1, exp_line(b, i)});
         end
         tick();
      end
      bus.msg_end = 1'b0;
      bus.d_rdy = 1'b1;
      bus.d = 8'($urandom);
      for (int j = 0; j < GapClks; j++) begin
         n_tests++;
         if ({bus.cd_busy, tx_oe, tx_line} !== 3'b110) begin
            n_fail++;
            $display("FAIL msg_gap cyc=%0d busy/oe/line got=%b exp=110", j,
                     {bus.cd_busy, tx_oe, tx_line});
         end
         tick();
      end
      bus.d_rdy = 1'b0;
      n_tests++;
      if ({bus.cd_busy, tx_oe} !== 2'b00) begin
         n_fail++;
         $display("FAIL msg_gap_end busy/oe got=%b exp=00", {bus.cd_busy, tx_oe});
      end
      tick();
      n_tests++;
      if (bus.cd_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL msg_gap_drdy_ignored busy got=%b exp=0", bus.cd_busy);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] b;
      bus.d = 8'h3C;
      bus.d_rdy = 1'b1;
      tick();
      bus.d_rdy = 1'b0;
      for (int i = 0; i < 4 * HBC; i++) begin
         bus.msg_end = (i == 2);
         n_tests++;
         if (tx_line !== exp_line(8'h3C, i)) begin
            n_fail++;
            $display("FAIL rstmid_byte cyc=%0d line got=%b exp=%b", i, tx_line, exp_line(8'h3C, i));
         end
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_tests++;
      if ({bus.cd_busy, tx_oe, tx_line} !== 3'b000) begin
         n_fail++;
         $display("FAIL rstmid_clear busy/oe/line got=%b exp=000", {bus.cd_busy, tx_oe, tx_line});
      end
      tick();
      tick();
      n_tests++;
      if (bus.cd_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_pend_cleared busy got=%b exp=0", bus.cd_busy);
      end
      b = 8'($urandom);
      bus.d = b;
      bus.d_rdy = 1'b1;
      tick();
      bus.d_rdy = 1'b0;
      for (int i = 0; i < ByteClks; i++) begin
         n_tests++;
         if ({bus.cd_busy, tx_line} !== {1'b1, exp_line(b, i)}) begin
            n_fail++;
            $display("FAIL rstmid_after b=%h cyc=%0d busy/line got=%b exp=%b", b, i,
                     {bus.cd_busy, tx_line}, {1'b1, exp_line(b, i)});
         end
         tick();
      end
      n_tests++;
      if (bus.cd_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_after_end busy got=%b exp=0", bus.cd_busy);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single();
      test_random();
      test_back_to_back();
      test_msg_end(1'b0);
      test_msg_end(1'b1);
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
